func_unit_seq: RTL and testbench
================================

// Module: func_unit_seq
// PURPOSE
//  Datapath function unit directly downstream of the 8x16 register file. Consumes its A/B read
//  data (AD/BD), performs the operation selected by FS and produces F plus V/C/N/Z status,
//  which feed back as the register-file write data (DD).
//  Single-cycle ops finish one edge after START; MUL is iterative shift-add with a BUSY/DONE handshake.
// PARAMETERS
//  WIDTH     16   operand/result width (must match register width)
//  CNT_W     5    iteration counter width, >= clog2(WIDTH+1)
// PORTS
//  CLK    in   1      rising-edge clock
//  RESET  in   1      asynchronous, active-low reset
//  A      in   WIDTH  operand A (from register-file AD)
//  B      in   WIDTH  operand B (from register-file BD)
//  FS     in   4      function select, sampled with START
//  START  in   1      request; accepted only in IDLE
//  BUSY   out  1      high while a MUL is iterating
//  DONE   out  1      one-cycle pulse: F/flags are valid and updated this cycle
//  F      out  WIDTH  result, held until the next completed op
//  V,C,N,Z out 1 each overflow, carry, negative, zero; held with F
// BEHAVIOUR
//  Reset (RESET=0, async): state=IDLE, F=0, V=C=N=0, Z=0, BUSY=0, DONE=0, counter=0, MUL regs=0.
//  FS: 0 A | 1 A+1 | 2 A+B | 3 A+B+1 | 4 A+~B | 5 A+~B+1 (A-B) | 6 A-1 | 7 A | 8 A&B | 9 A|B
//      | A A^B | B ~A | C B | D B>>1 (logical) | E B<<1 | F MUL (low WIDTH bits of A*B, unsigned).
//  Arithmetic (0-7): computed on WIDTH+1 bits; C=bit WIDTH; V=(sign A==sign of 2nd operand)
//    && (sign F != sign A), 2nd operand being B, ~B, +1 or all-ones as applicable.
//  Logic/pass (8-C): C=0, V=0.  Shifts: C=bit shifted out (B[0] for D, B[WIDTH-1] for E), V=0.
//  N=F[WIDTH-1], Z=(F==0) for every op, computed from the new F.
//  FSM states IDLE, MUL:
//   IDLE & START & FS!=F: next edge loads F/flags, DONE=1 for that one cycle, stay IDLE. Latency 1.
//   IDLE & START & FS==F: capture A (multiplicand), B (multiplier), clear acc (2*WIDTH bits),
//     counter=0, BUSY=1, go MUL.  DONE stays 0 on the capture edge.
//   MUL: each edge, if multiplier[0] add multiplicand<<counter into acc; shift multiplier right;
//     counter++.  After WIDTH iterations: F=acc[WIDTH-1:0], C=|acc[2W-1:W], V=0, N/Z from F;
//     BUSY=0, DONE=1, back to IDLE.  START to DONE = WIDTH+1 edges.
//  START while BUSY: ignored, no queueing; A/B/FS changes during MUL do not affect the result.
//  START in the cycle DONE is high (IDLE): accepted normally (back-to-back ops, 1/cycle).
//  DONE never asserts without a preceding accepted START; F/flags change only on a DONE cycle.
//  RESET asserted mid-MUL: abort immediately, all outputs to reset values, no DONE.
//  Unknown/X FS never possible: all 16 codes defined.
// STRUCTURE
//  Shared package (datapath_pkg): FS code constants (FS_PASSA..FS_MUL), state enum {IDLE,MUL},
//    WIDTH default.  Shared with control/decoder that drives FS.
//  One sub-module: fu_alu_comb -- purely combinational ops 0-E returning {F,V,C}; top holds FSM,
//    iterative multiplier, output/flag registers and N/Z generation.
// TESTING
//  1 Reset: RESET=0 mid-run -> F=0, flags=0, BUSY=0, DONE=0 asynchronously, before next CLK.
//  2 Add/sub: A=7FFF,B=0001,FS=2 -> F=8000,V=1,C=0,N=1,Z=0 one edge later; A=0005,B=0005,FS=5
//    -> F=0000,C=1,V=0,Z=1; DONE single pulse each.
//  3 Logic/shift: A=F0F0,B=0FF0,FS=8 -> F=00F0,C=0; B=8001,FS=E -> F=0002,C=1; FS=D -> F=4000,C=1.
//  4 MUL: A=0012,B=0034,FS=F -> BUSY 16 cycles, DONE on edge 17, F=03A8,C=0; A=FFFF,B=0002
//    -> F=FFFE,C=1,N=1.
//  5 Handshake: START pulses during BUSY with FS=2 -> ignored, MUL result unchanged; A/B toggled
//    during MUL -> no effect; START on DONE cycle -> next op completes one edge later.
//  6 Reset mid-MUL at iteration 8 -> no DONE; after release, new FS=0 A=1234 -> F=1234 in 1 edge.

Source files
------------

// File: rtl/datapath_pkg.sv
// Shared datapath definitions: function-select codes, FSM state type and default widths.
// The control/decoder that drives FS imports the same codes.
package datapath_pkg;

    localparam int unsigned WIDTH_DEF = 16;
    localparam int unsigned CNT_W_DEF = 5;

    // Function-select codes
    localparam logic [3:0] FS_PASSA   = 4'h0;  // A
    localparam logic [3:0] FS_INCA    = 4'h1;  // A+1
    localparam logic [3:0] FS_ADD     = 4'h2;  // A+B
    localparam logic [3:0] FS_ADDINC  = 4'h3;  // A+B+1
    localparam logic [3:0] FS_ADDNOTB = 4'h4;  // A+~B
    localparam logic [3:0] FS_SUB     = 4'h5;  // A+~B+1
    localparam logic [3:0] FS_DECA    = 4'h6;  // A-1
    localparam logic [3:0] FS_PASSA2  = 4'h7;  // A
    localparam logic [3:0] FS_AND     = 4'h8;
    localparam logic [3:0] FS_OR      = 4'h9;
    localparam logic [3:0] FS_XOR     = 4'hA;
    localparam logic [3:0] FS_NOTA    = 4'hB;
    localparam logic [3:0] FS_PASSB   = 4'hC;
    localparam logic [3:0] FS_SHR     = 4'hD;  // B>>1, logical
    localparam logic [3:0] FS_SHL     = 4'hE;  // B<<1
    localparam logic [3:0] FS_MUL     = 4'hF;  // iterative, handled by the top

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

endpackage

// File: rtl/fu_alu_comb.sv
// Combinational part of the function unit: every single-cycle operation (codes 0-E).
// Returns the result with overflow and carry; N/Z are derived by the caller.
module fu_alu_comb
    import datapath_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       FS,
    output logic [WIDTH-1:0] F,
    output logic             V,
    output logic             C
);

    logic [WIDTH-1:0] op2;
    logic             cin;
    logic             arith;
    logic [WIDTH:0]   cin_ext;
    logic [WIDTH:0]   sum;

    // Decode FS into either an adder setup or a direct logic/shift result
    always_comb begin
        op2     = '0;
        cin     = 1'b0;
        arith   = 1'b0;
        F       = '0;
        V       = 1'b0;
        C       = 1'b0;
        cin_ext = '0;
        sum     = '0;
        case (FS)
            FS_PASSA, FS_PASSA2: arith = 1'b1;
            FS_INCA:    begin arith = 1'b1; cin = 1'b1; end
            FS_ADD:     begin arith = 1'b1; op2 = B; end
            FS_ADDINC:  begin arith = 1'b1; op2 = B; cin = 1'b1; end
            FS_ADDNOTB: begin arith = 1'b1; op2 = ~B; end
            FS_SUB:     begin arith = 1'b1; op2 = ~B; cin = 1'b1; end
            FS_DECA:    begin arith = 1'b1; op2 = '1; end
            FS_AND:     F = A & B;
            FS_OR:      F = A | B;
            FS_XOR:     F = A ^ B;
            FS_NOTA:    F = ~A;
            FS_PASSB:   F = B;
            FS_SHR:     begin F = {1'b0, B[WIDTH-1:1]}; C = B[0]; end
            FS_SHL:     begin F = {B[WIDTH-2:0], 1'b0}; C = B[WIDTH-1]; end
            default:    ;  // FS_MUL is produced by the iterative path in the top
        endcase
        cin_ext = {{WIDTH{1'b0}}, cin};
        sum     = {1'b0, A} + {1'b0, op2} + cin_ext;
        if (arith) begin
            F = sum[WIDTH-1:0];
            C = sum[WIDTH];
            // The +1 carry-in counts as a non-negative second operand, so op2's sign stands in
            V = (A[WIDTH-1] == op2[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
        end
    end

endmodule

// File: rtl/func_unit_seq.sv
// Sequential function unit: single-cycle ALU ops plus an iterative shift-add multiplier.
// Results and V/C/N/Z flags are registered and only change on a DONE cycle.
module func_unit_seq
    import datapath_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       FS,
    input  logic             START,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] F,
    output logic             V,
    output logic             C,
    output logic             N,
    output logic             Z
);

    state_t             state_q;
    logic [WIDTH-1:0]   f_q;
    logic               v_q, c_q, n_q, z_q;
    logic               busy_q, done_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [2*WIDTH-1:0] acc_q;

    logic [WIDTH-1:0]   alu_f;
    logic               alu_v, alu_c;
    logic [2*WIDTH-1:0] addend;
    logic [2*WIDTH-1:0] acc_next;
    logic               mul_last;

    fu_alu_comb #(
        .WIDTH (WIDTH)
    ) u_alu (
        .A  (A),
        .B  (B),
        .FS (FS),
        .F  (alu_f),
        .V  (alu_v),
        .C  (alu_c)
    );

    // One shift-add step of the multiplier; the final step is folded into the result load
    always_comb begin
        addend   = {{WIDTH{1'b0}}, mcand_q} << cnt_q;
        acc_next = mplier_q[0] ? (acc_q + addend) : acc_q;
        mul_last = (cnt_q == CNT_W'(WIDTH - 1));
    end

    // Control FSM with registered result, flags and handshake outputs
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q  <= IDLE;
            f_q      <= '0;
            v_q      <= 1'b0;
            c_q      <= 1'b0;
            n_q      <= 1'b0;
            z_q      <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (START) begin
                        if (FS == FS_MUL) begin
                            mcand_q  <= A;
                            mplier_q <= B;
                            acc_q    <= '0;
                            cnt_q    <= '0;
                            busy_q   <= 1'b1;
                            state_q  <= MUL;
                        end else begin
                            f_q    <= alu_f;
                            v_q    <= alu_v;
                            c_q    <= alu_c;
                            n_q    <= alu_f[WIDTH-1];
                            z_q    <= (alu_f == '0);
                            done_q <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    acc_q    <= acc_next;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + CNT_W'(1);
                    if (mul_last) begin
                        f_q     <= acc_next[WIDTH-1:0];
                        c_q     <= |acc_next[2*WIDTH-1:WIDTH];
                        v_q     <= 1'b0;
                        n_q     <= acc_next[WIDTH-1];
                        z_q     <= (acc_next[WIDTH-1:0] == '0);
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

    assign F    = f_q;
    assign V    = v_q;
    assign C    = c_q;
    assign N    = n_q;
    assign Z    = z_q;
    assign BUSY = busy_q;
    assign DONE = done_q;

endmodule

// File: tb/tb_func_unit_seq.sv
// Directed bench for func_unit_seq: expected results are queued at issue time and
// compared by a monitor whenever DONE pulses; handshake timing is checked inline.
module tb_func_unit_seq;
    import datapath_pkg::*;

    typedef struct packed {
        logic [15:0] f;
        logic        v;
        logic        c;
        logic        n;
        logic        z;
    } res_t;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [15:0] A, B;
    logic [3:0]  FS;
    logic        START;
    logic        BUSY, DONE;
    logic [15:0] F;
    logic        V, C, N, Z;

    int   checks   = 0;
    int   failures = 0;
    res_t sb[$];
    res_t last_res = '0;

    func_unit_seq #(
        .WIDTH (16),
        .CNT_W (5)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .A     (A),
        .B     (B),
        .FS    (FS),
        .START (START),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .F     (F),
        .V     (V),
        .C     (C),
        .N     (N),
        .Z     (Z)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: integer arithmetic, independent of the adder structure
    function automatic res_t model(input logic [3:0] fs, input logic [15:0] a,
                                   input logic [15:0] b);
        res_t        r;
        logic [15:0] o;
        logic        ci;
        logic        arith;
        int          u;
        int          s;
        logic [31:0] p;
        r = '0; o = '0; ci = 1'b0; arith = 1'b0;
        p = {16'b0, a} * {16'b0, b};
        case (fs)
            4'd0, 4'd7: arith = 1'b1;
            4'd1:  begin arith = 1'b1; ci = 1'b1; end
            4'd2:  begin arith = 1'b1; o = b; end
            4'd3:  begin arith = 1'b1; o = b; ci = 1'b1; end
            4'd4:  begin arith = 1'b1; o = ~b; end
            4'd5:  begin arith = 1'b1; o = ~b; ci = 1'b1; end
            4'd6:  begin arith = 1'b1; o = 16'hFFFF; end
            4'd8:  r.f = a & b;
            4'd9:  r.f = a | b;
            4'd10: r.f = a ^ b;
            4'd11: r.f = ~a;
            4'd12: r.f = b;
            4'd13: begin r.f = b >> 1; r.c = b[0]; end
            4'd14: begin r.f = b << 1; r.c = b[15]; end
            default: begin r.f = p[15:0]; r.c = |p[31:16]; end
        endcase
        if (arith) begin
            u = int'({16'b0, a}) + int'({16'b0, o}) + int'({31'b0, ci});
            s = int'($signed(a)) + int'($signed(o)) + int'({31'b0, ci});
            r.f = u[15:0];
            r.c = u[16];
            r.v = (s > 32767) || (s < -32768);
        end
        r.n = r.f[15];
        r.z = (r.f == 16'h0000);
        return r;
    endfunction

    task automatic issue_exp(input logic [3:0] fs, input logic [15:0] a, input logic [15:0] b,
                             input res_t exp);
        FS = fs; A = a; B = b; START = 1'b1;
        sb.push_back(exp);
    endtask

    task automatic issue(input logic [3:0] fs, input logic [15:0] a, input logic [15:0] b);
        issue_exp(fs, a, b, model(fs, a, b));
    endtask

    // Wait (bounded) for DONE, checking latency, BUSY duration and that DONE is one pulse
    task automatic wait_done(input string tag, input int exp_lat, input int exp_busy);
        int n = 0;
        int nb = 0;
        while (n < 40) begin
            @(negedge CLK);
            n++;
            START = 1'b0;
            if (BUSY === 1'b1) nb++;
            if (DONE === 1'b1) break;
        end
        chk({tag, "_latency"}, 32'(n), 32'(exp_lat));
        chk({tag, "_busy_cycles"}, 32'(nb), 32'(exp_busy));
        @(negedge CLK);
        chk({tag, "_done_pulse"}, 32'(DONE), 32'(0));
    endtask

    // Scoreboard monitor: results on DONE, otherwise F/flags must hold
    always @(negedge CLK) begin
        if (RESET !== 1'b1) begin
            last_res = '0;
        end else if (DONE === 1'b1) begin
            if (sb.size() == 0) begin
                chk("done_without_start", 32'(DONE), 32'(0));
            end else begin
                res_t e;
                e = sb.pop_front();
                chk("result", 32'({F, V, C, N, Z}), 32'(e));
                last_res = e;
            end
        end else begin
            chk("held_between_ops", 32'({F, V, C, N, Z}), 32'(last_res));
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        RESET = 1'b1; START = 1'b0; A = '0; B = '0; FS = '0;
        #1 RESET = 1'b0;
        #1 chk("reset_outputs", 32'({F, V, C, N, Z, BUSY, DONE}), 32'(0));
        repeat (2) @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);

        // Arithmetic
        issue_exp(FS_ADD, 16'h7FFF, 16'h0001, {16'h8000, 1'b1, 1'b0, 1'b1, 1'b0});
        wait_done("add_ovf", 1, 0);
        issue_exp(FS_SUB, 16'h0005, 16'h0005, {16'h0000, 1'b0, 1'b1, 1'b0, 1'b1});
        wait_done("sub_zero", 1, 0);

        // Logic and shifts
        issue_exp(FS_AND, 16'hF0F0, 16'h0FF0, {16'h00F0, 1'b0, 1'b0, 1'b0, 1'b0});
        wait_done("and", 1, 0);
        issue_exp(FS_SHL, 16'hF0F0, 16'h8001, {16'h0002, 1'b0, 1'b1, 1'b0, 1'b0});
        wait_done("shl", 1, 0);
        issue_exp(FS_SHR, 16'hF0F0, 16'h8001, {16'h4000, 1'b0, 1'b1, 1'b0, 1'b0});
        wait_done("shr", 1, 0);

        // Multiply
        issue_exp(FS_MUL, 16'h0012, 16'h0034, {16'h03A8, 1'b0, 1'b0, 1'b0, 1'b0});
        wait_done("mul_small", 17, 16);
        issue_exp(FS_MUL, 16'hFFFF, 16'h0002, {16'hFFFE, 1'b0, 1'b1, 1'b1, 1'b0});
        wait_done("mul_carry", 17, 16);

        // Every code with random operands against the model
        for (int k = 0; k < 16; k++) begin
            issue(k[3:0], 16'($urandom), 16'($urandom));
            wait_done($sformatf("rand_fs%0d", k), (k == 15) ? 17 : 1, (k == 15) ? 16 : 0);
        end

        // START and operand changes during MUL are ignored; back-to-back op on DONE cycle
        issue(FS_MUL, 16'h0003, 16'h0005);
        for (int i = 1; i <= 16; i++) begin
            @(negedge CLK);
            chk("busy_during_mul", 32'(BUSY), 32'(1));
            chk("no_early_done", 32'(DONE), 32'(0));
            START = i[0];
            FS = FS_ADD;
            A = 16'($urandom);
            B = 16'($urandom);
        end
        @(negedge CLK);
        chk("mul_done_edge17", 32'(DONE), 32'(1));
        issue_exp(FS_ADD, 16'h0001, 16'h0002, {16'h0003, 1'b0, 1'b0, 1'b0, 1'b0});
        @(negedge CLK);
        START = 1'b0;
        chk("back_to_back_done", 32'(DONE), 32'(1));
        @(negedge CLK);
        chk("back_to_back_single", 32'(DONE), 32'(0));

        // Reset mid-MUL: immediate abort, no DONE afterwards
        issue(FS_MUL, 16'h1234, 16'h5678);
        @(negedge CLK);
        START = 1'b0;
        repeat (7) @(negedge CLK);
        #2 RESET = 1'b0;
        #1 chk("reset_mid_mul", 32'({F, V, C, N, Z, BUSY, DONE}), 32'(0));
        sb.delete();
        repeat (2) @(negedge CLK);
        RESET = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (i % 5 == 0) chk("no_done_after_abort", 32'({BUSY, DONE}), 32'(0));
        end
        issue_exp(FS_PASSA, 16'h1234, 16'hABCD, {16'h1234, 1'b0, 1'b0, 1'b0, 1'b0});
        wait_done("pass_after_reset", 1, 0);

        chk("scoreboard_drained", 32'(sb.size()), 32'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
